// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - frame constants, position table and FSM encoding for the Hamming receiver
// Optional feature macro: HAMMING_PARIDADE_GLOBAL_EN (adds position 16 overall parity, SECDED)
package hamming_pkg;

  localparam int FRAME_LEN_BASE   = 15;
  localparam int FRAME_LEN_SECDED = 16;

`ifdef HAMMING_PARIDADE_GLOBAL_EN
  localparam int FRAME_LEN = FRAME_LEN_SECDED;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  localparam int DATA_W = 11;
  localparam int SIND_W = 4;

  // Parity bits sit at the power-of-two positions; each one covers the
  // positions whose index has the same bit set.
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEBE  = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  // Parity position that drives syndrome bit j.
  function automatic int parity_pos(input int j);
    case (j)
      0:       return POS_P1;
      1:       return POS_P2;
      2:       return POS_P4;
      default: return POS_P8;
    endcase
  endfunction

  // Codeword position holding dado[k]; data fills the non-parity slots in ascending order.
  function automatic int data_pos(input int k);
    case (k)
      0:       return 3;
      1:       return 5;
      2:       return 6;
      3:       return 7;
      4:       return 9;
      5:       return 10;
      6:       return 11;
      7:       return 12;
      8:       return 13;
      9:       return 14;
      default: return 15;
    endcase
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// rtl/hamming_sindrome.sv - combinational syndrome, single-bit correction and data extraction
// Optional feature macro: HAMMING_PARIDADE_GLOBAL_EN (overall parity decides correct vs double error)
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [FRAME_LEN-1:0] frame,
  output logic [DATA_W-1:0]    dado,
  output logic [SIND_W-1:0]    sindrome,
  output logic                 corrigido,
  output logic                 erro_duplo
);

  logic [SIND_W-1:0]         sind;
  logic                      flip_en;
  logic [FRAME_LEN_BASE-1:0] fixed;

  // Syndrome over positions 1..15, correction decision, then data pick-out
  always_comb begin
    sind = '0;
    for (int j = 0; j < SIND_W; j++) begin
      for (int p = 1; p <= FRAME_LEN_BASE; p++) begin
        if ((p & parity_pos(j)) != 0) begin
          sind[j] = sind[j] ^ frame[p-1];
        end
      end
    end

`ifdef HAMMING_PARIDADE_GLOBAL_EN
    // Odd overall parity means an odd number of flips: trust the syndrome.
    // Nonzero syndrome with even parity is two flips and must not be touched.
    flip_en    = (sind != '0) && (^frame);
    corrigido  = ^frame;
    erro_duplo = (sind != '0) && !(^frame);
`else
    flip_en    = (sind != '0);
    corrigido  = (sind != '0);
    erro_duplo = 1'b0;
`endif

    fixed = frame[FRAME_LEN_BASE-1:0];
    for (int p = 1; p <= FRAME_LEN_BASE; p++) begin
      if (flip_en && (sind == 4'(p))) begin
        fixed[p-1] = ~fixed[p-1];
      end
    end

    dado = '0;
    for (int k = 0; k < DATA_W; k++) begin
      dado[k] = fixed[data_pos(k)-1];
    end

    sindrome = sind;
  end

endmodule

// File: rtl/receptor_hamming.sv
// rtl/receptor_hamming.sv - serial Hamming frame receiver with correction and corrected-frame counter
// Optional feature macro: HAMMING_PARIDADE_GLOBAL_EN (16-bit SECDED frame, erro_duplo active)
module receptor_hamming
  import hamming_pkg::*;
#(
  parameter int CONT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              serial_valid,
  input  logic              start,
  output logic [DATA_W-1:0] dado,
  output logic              dado_valid,
  output logic              corrigido,
  output logic [SIND_W-1:0] sindrome,
  output logic              erro_duplo,
  output logic [CONT_W-1:0] cont_corrigidos,
  output logic              busy
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  estado_t                estado_q;
  estado_t                estado_d;
  logic [FRAME_LEN-1:0]   frame_q;
  logic [FRAME_LEN-1:0]   frame_d;
  logic [3:0]             pos_q;
  logic [3:0]             pos_d;
  logic                   carrega_inicio;
  logic                   carrega_prox;
  logic                   ultimo;
  logic [DATA_W-1:0]      dec_dado;
  logic [SIND_W-1:0]      dec_sindrome;
  logic                   dec_corrigido;
  logic                   dec_erro_duplo;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:    if (carrega_inicio) estado_d = RECEBE;
      RECEBE:  if (ultimo) estado_d = ENTREGA;
      ENTREGA: estado_d = carrega_inicio ? RECEBE : IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // FSM outputs and bit-load strobes; a start bit always opens a fresh frame
  always_comb begin
    carrega_inicio = serial_valid && start;
    carrega_prox   = (estado_q == RECEBE) && serial_valid && !start;
    ultimo         = carrega_prox && (pos_q == LAST_IDX);
    busy           = (estado_q == RECEBE);
    dado_valid     = (estado_q == ENTREGA);
  end

  // Next frame contents including the bit sampled this cycle
  always_comb begin
    frame_d = frame_q;
    pos_d   = pos_q;
    if (carrega_inicio) begin
      frame_d[0] = serial_in;
      pos_d      = 4'd1;
    end else if (carrega_prox) begin
      frame_d[pos_q] = serial_in;
      pos_d          = pos_q + 4'd1;
    end
  end

  // Frame shift storage and write position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      pos_q   <= '0;
    end else begin
      frame_q <= frame_d;
      pos_q   <= pos_d;
    end
  end

  // Decoding works on the next-frame view so results land as ENTREGA begins
  hamming_sindrome u_sindrome (
    .frame      (frame_d),
    .dado       (dec_dado),
    .sindrome   (dec_sindrome),
    .corrigido  (dec_corrigido),
    .erro_duplo (dec_erro_duplo)
  );

  // Result registers, held until the next frame completes; saturating counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dado            <= '0;
      sindrome        <= '0;
      corrigido       <= 1'b0;
      erro_duplo      <= 1'b0;
      cont_corrigidos <= '0;
    end else if (ultimo) begin
      dado       <= dec_dado;
      sindrome   <= dec_sindrome;
      corrigido  <= dec_corrigido;
      erro_duplo <= dec_erro_duplo;
      if (dec_corrigido && (cont_corrigidos != {CONT_W{1'b1}})) begin
        cont_corrigidos <= cont_corrigidos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_receptor_hamming.sv
// tb/tb_receptor_hamming.sv - randomized self-checking bench with behavioural Hamming model
module tb_receptor_hamming;

`ifdef HAMMING_PARIDADE_GLOBAL_EN
  localparam int FL = 16;
  localparam bit SECDED = 1'b1;
`else
  localparam int FL = 15;
  localparam bit SECDED = 1'b0;
`endif
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          serial_in;
  logic          serial_valid;
  logic          start;
  logic [10:0]   dado;
  logic          dado_valid;
  logic          corrigido;
  logic [3:0]    sindrome;
  logic          erro_duplo;
  logic [CW-1:0] cont_corrigidos;
  logic          busy;

  receptor_hamming #(.CONT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .serial_in       (serial_in),
    .serial_valid    (serial_valid),
    .start           (start),
    .dado            (dado),
    .dado_valid      (dado_valid),
    .corrigido       (corrigido),
    .sindrome        (sindrome),
    .erro_duplo      (erro_duplo),
    .cont_corrigidos (cont_corrigidos),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0]   dado;
    logic [3:0]    sind;
    logic          corr;
    logic          dup;
    logic [CW-1:0] cont;
    int            cyc;
  } exp_t;

  exp_t        q[$];
  logic [10:0] hold_dado = '0;
  int          model_cont = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hamming encoder straight from the rules: data into non-power-of-two slots, even parity groups
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        par;
    cw = '0;
    for (int k = 0; k < 11; k++) cw[DPOS[k]-1] = d[k];
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) if ((p >> j) & 1) par ^= cw[p-1];
      cw[(1 << j) - 1] = par;
    end
    cw[15] = ^cw[14:0];
    return cw;
  endfunction

  function automatic exp_t mk(input logic [10:0] d, input logic [3:0] s, input logic c,
                              input logic du, input int cont);
    exp_t e;
    e.dado = d; e.sind = s; e.corr = c; e.dup = du; e.cont = CW'(cont); e.cyc = 0;
    return e;
  endfunction

  // Expected result from the original data and the set of flipped positions
  task automatic model(input logic [10:0] d, input logic [15:0] mask, output exp_t e);
    int n;
    int s;
    n = $countones(mask);
    s = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) s ^= (i + 1) % 16;
    e = mk(d, 4'd0, 1'b0, 1'b0, 0);
    if (n == 1) begin
      e.sind = 4'(s);
      e.corr = 1'b1;
    end else if (n == 2) begin
      e.sind = 4'(s);
      e.dup  = 1'b1;
      for (int k = 0; k < 11; k++) if (mask[DPOS[k]-1]) e.dado[k] = ~e.dado[k];
    end
    if (e.corr && model_cont < CMAX) model_cont++;
    e.cont = CW'(model_cont);
  endtask

  // Compare process: every delivered word against the queue head, plus hold and latency
  always @(negedge clk) begin
    exp_t e;
    if (dado_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_dado_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("dado", dado, e.dado);
        chk("sindrome", sindrome, e.sind);
        chk("corrigido", corrigido, e.corr);
        chk("erro_duplo", erro_duplo, e.dup);
        chk("cont_corrigidos", cont_corrigidos, e.cont);
        chk("latency_cycle", cyc, e.cyc);
      end
      hold_dado = dado;
    end else begin
      chk("dado_hold", dado, hold_dado);
      if (q.size() > 0 && cyc > q[0].cyc) begin
        tests++; fails++;
        $display("FAIL missing_dado_valid: got 0 expected 1 (cycle %0d)", q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic s, input logic b);
    serial_valid = v; start = s; serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dado"}, dado, 0);
    chk({tag, "_dado_valid"}, dado_valid, 0);
    chk({tag, "_corrigido"}, corrigido, 0);
    chk({tag, "_sindrome"}, sindrome, 0);
    chk({tag, "_erro_duplo"}, erro_duplo, 0);
    chk({tag, "_cont"}, cont_corrigidos, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Reset with start/serial_valid asserted to show reset wins
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    serial_valid = 1'b0; start = 1'b0;
    hold_dado = '0;
    model_cont = 0;
  endtask

  task automatic send_frame(input logic [15:0] cw, input int gap, input exp_t e);
    for (int i = 0; i < FL; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          chk("busy_gap", busy, 1);
        end
      end
      if (i == FL - 1) begin
        e.cyc = cyc + 1;
        q.push_back(e);
      end
      drive(1'b1, i == 0, cw[i]);
      chk(i == FL - 1 ? "busy_end" : "busy_mid", busy, (i < FL - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [15:0] cwv;
    logic [15:0] mask;
    logic [10:0] d;
    exp_t        e;
    int          n, a, b;

    serial_valid = 1'b0; start = 1'b0; serial_in = 1'b0;
    do_reset(2);
    check_all_zero("reset");

    // Pin the encoder on hand-computed codewords
    cwv = encode(11'h7FF);
    chk("enc_7ff", cwv[14:0], 15'h7FFF);
    cwv = encode(11'h001);
    chk("enc_001", cwv[14:0], 15'h0007);

    // All-ones clean frame, contiguous
    send_frame(encode(11'h7FF), 0, mk(11'h7FF, 4'd0, 1'b0, 1'b0, 0));
    drive(1'b0, 1'b0, 1'b0);

    // Zero codeword, position 5 flipped
    send_frame(encode(11'h000) ^ 16'h0010, 0, mk(11'h000, 4'd5, 1'b1, 1'b0, 1));
    drive(1'b0, 1'b0, 1'b0);

    // All-ones codeword, position 12 flipped, three idle cycles between bits
    send_frame(encode(11'h7FF) ^ 16'h0800, 3, mk(11'h7FF, 4'd12, 1'b1, 1'b0, 2));
    drive(1'b0, 1'b0, 1'b0);

    // Restart after 7 bits, then a full clean frame gives exactly one delivery
    cwv = encode(11'h123);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, i == 0, cwv[i]);
      chk("busy_partial", busy, 1);
    end
    send_frame(encode(11'h7FF), 0, mk(11'h7FF, 4'd0, 1'b0, 1'b0, 2));
    drive(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame; following bits without start are ignored
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, cwv[i]);
    do_reset(1);
    check_all_zero("midreset");
    for (int i = 5; i < FL; i++) begin
      drive(1'b1, 1'b0, cwv[i]);
      chk("busy_ignored", busy, 0);
    end
    drive(1'b0, 1'b0, 1'b0);

    // Counter saturation with a 2-bit counter
    do_reset(1);
    for (int f = 0; f < 5; f++) begin
      d = 11'($urandom);
      a = $urandom_range(1, 15);
      send_frame(encode(d) ^ (16'h1 << (a - 1)), f % 2,
                 mk(d, 4'(a), 1'b1, 1'b0, (f < 3) ? f + 1 : 3));
    end
    drive(1'b0, 1'b0, 1'b0);

    if (SECDED) begin
      // Double error: positions 3 and 6 on an all-zero frame
      do_reset(1);
      send_frame(16'h0024, 1, mk(11'h005, 4'd5, 1'b0, 1'b1, 0));
      drive(1'b0, 1'b0, 1'b0);
    end

    // Randomized frames against the behavioural model
    do_reset(1);
    for (int f = 0; f < 40; f++) begin
      d = 11'($urandom);
      n = SECDED ? $urandom_range(0, 2) : $urandom_range(0, 1);
      mask = '0;
      a = $urandom_range(1, FL);
      b = a;
      while (b == a) b = $urandom_range(1, FL);
      if (n >= 1) mask[a-1] = 1'b1;
      if (n == 2) mask[b-1] = 1'b1;
      model(d, mask, e);
      send_frame(encode(d) ^ mask, $urandom_range(0, 2), e);
      for (int g = $urandom_range(0, 2); g > 0; g--) drive(1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    chk("pending_expectations", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/receptor_hamming.md
RECEPTOR_HAMMING -- requirements
Module: receptor_hamming

Interface
REQ-001 CONT_W, 8, width of saturating corrected-frame counter.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 serial_in  in  1  codeword bit, sampled when serial_valid=1.
REQ-005 serial_valid  in  1  qualifies serial_in; gaps of any length allowed.
REQ-006 start  in  1  frame sync; marks the sampled bit as position 1.
REQ-007 dado  out  11  corrected data word, held until next frame completes.
REQ-008 dado_valid  out  1  one-cycle pulse, dado/flags valid.
REQ-009 corrigido  out  1  frame had a single-bit error, corrected.
REQ-010 sindrome  out  4  syndrome of last completed frame.
REQ-011 erro_duplo  out  1  uncorrectable double error (SECDED build only, else 0).
REQ-012 cont_corrigidos  out  CONT_W  count of frames with corrigido=1.
REQ-013 busy  out  1  high while a frame is partially received.

Function
REQ-014 Codeword positions 1..15 (16 with SECDED); parity at 1,2,4,8; dado[0]..dado[10] at positions 3,5,6,7,9,10,11,12,13,14,15 ascending.
REQ-015 Serial order: position 1 first, ascending.
REQ-016 FSM states: IDLE, RECEBE, ENTREGA.
REQ-017 IDLE -> RECEBE when serial_valid=1 and start=1; that bit stored as position 1; bits without start ignored.
REQ-018 RECEBE: each serial_valid=1 cycle stores next position; after last position -> ENTREGA.
REQ-019 start=1 with serial_valid=1 in RECEBE discards partial frame and restarts with that bit as position 1.
REQ-020 ENTREGA lasts one cycle: registered dado, sindrome, corrigido, erro_duplo update and dado_valid=1; then -> IDLE, or -> RECEBE if start and serial_valid are both 1 that cycle.
REQ-021 Latency: dado_valid asserts the cycle after the last bit is sampled.
REQ-022 Syndrome bit j = XOR of received bits at positions with bit j set; nonzero syndrome flips that position before data extraction.
REQ-023 corrigido = (sindrome != 0) in non-SECDED build.
REQ-024 cont_corrigidos increments on each dado_valid with corrigido=1, saturates at 2^CONT_W-1, cleared only by reset.
REQ-025 busy = 1 in RECEBE, 0 otherwise.

Reset
REQ-026 rst_n=0 at a clock edge: state IDLE, partial frame discarded, dado=0, dado_valid=0, corrigido=0, sindrome=0, erro_duplo=0, cont_corrigidos=0, busy=0.
REQ-027 Reset dominates start/serial_valid in the same cycle.

Configuration
REQ-028 Macro HAMMING_PARIDADE_GLOBAL_EN defined: frame is 16 bits, position 16 = overall even parity over positions 1..15.
REQ-029 With macro: p = XOR of all 16 bits; s!=0,p=1 -> correct, corrigido=1; s!=0,p=0 -> no correction, erro_duplo=1, corrigido=0; s=0,p=1 -> corrigido=1, data unchanged; s=0,p=0 -> clean.
REQ-030 Without macro: 15-bit frame, erro_duplo tied 0.

Structure
REQ-031 Package hamming_pkg: frame length constants (15/16), data-position table, parity-position constants, FSM state encodings.
REQ-032 Sub-module hamming_sindrome: combinational syndrome computation, correction and data extraction, reused by FSM wrapper.

Verification
REQ-033 Data 0x7FF, codeword 0x7FFF sent contiguously -> dado=0x7FF, sindrome=0, corrigido=0, dado_valid one cycle after bit 15.
REQ-034 Codeword 0 with position 5 flipped -> dado=0x000, sindrome=5, corrigido=1, cont_corrigidos=1.
REQ-035 Codeword 0x7FFF with position 12 flipped, serial_valid low 3 cycles between each bit -> dado=0x7FF, sindrome=12, busy high throughout.
REQ-036 start reasserted after 7 bits, then full clean frame of 0x7FF -> single dado_valid, dado=0x7FF; rst_n=0 mid-frame -> no dado_valid, all outputs 0.
REQ-037 CONT_W=2, five frames each with one flipped bit -> cont_corrigidos 1,2,3,3,3.
REQ-038 SECDED build, all-zero 16-bit frame with positions 3 and 6 flipped -> erro_duplo=1, corrigido=0, sindrome=5, dado unchanged from received data bits.
